read_control: RTL

- Reader side of the TRU sample ring buffer.
- The write side fills a 256-deep circular buffer and freezes it on L1/L2. It also captures the write address at L0 and waits for readout to finish.
- This block reads a window of samples from the frozen buffer, starting PRE_SAMPLES before the L0 address.
- It streams the samples to the readout link with a valid/ready handshake, then pulses readout_end so the write side returns to idle.

---
 rtl/read_control_pkg.sv | 19 +
 rtl/rd_skid_fifo.sv | 68 ++++++
 rtl/read_control.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/read_control_pkg.sv
// -----------------------------------------------------------------------------
// read_control_pkg
// Shared definitions for the reader side of the TRU sample ring buffer.
//   - Default buffer address / sample widths (shared with the write side).
//   - Reader FSM state encoding.
// -----------------------------------------------------------------------------
package read_control_pkg;

  localparam int DEFAULT_ADDR_W = 8;
  localparam int DEFAULT_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    END   = 2'd3
  } state_t;

endpackage : read_control_pkg

// File: rtl/rd_skid_fifo.sv
// -----------------------------------------------------------------------------
// rd_skid_fifo
// Two-entry FIFO between the buffer read pipeline and the readout link.
// The producer has no ready: the reader only issues a read when a slot is
// guaranteed, so in_valid is never asserted into a full FIFO.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   in_valid   push in_data this cycle
//   in_data    word to push
//   out_valid  head word is valid
//   out_data   head word
//   out_ready  consumer pops the head when out_valid & out_ready
//   count      current occupancy (0..2)
// -----------------------------------------------------------------------------
module rd_skid_fifo #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic              push;
  logic              pop;

  assign push      = in_valid;
  assign pop       = out_valid & out_ready;
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the storage is reset as well, so dout reads 0 straight out of
      // reset; with only two entries this costs nothing worth avoiding.
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule : rd_skid_fifo

// File: rtl/read_control.sv
// -----------------------------------------------------------------------------
// read_control
// Reader side of the TRU sample ring buffer. On readout_start it reads a
// window of N_SAMPLES words from the frozen circular buffer, beginning
// PRE_SAMPLES before the L0 address, streams them out over valid/ready and
// then pulses readout_end so the write side can return to idle.
//
// Optional feature (macro READ_CHECKSUM_EN): a DATA_W running sum of every
// accepted sample is appended as a trailer word carrying dout_last.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous, active-low reset
//   readout_start  one-cycle readout request (ignored while busy)
//   address_L0     L0 buffer address, sampled on readout_start
//   rd_address     buffer read address
//   rd_en          buffer read enable (rd_data valid one cycle later)
//   rd_data        buffer read data
//   dout           output sample
//   dout_valid     dout is valid
//   dout_ready     consumer accepts on dout_valid & dout_ready
//   dout_last      final word of the readout
//   busy           readout in progress
//   readout_end    one-cycle completion pulse
// -----------------------------------------------------------------------------
module read_control
  import read_control_pkg::*;
#(
  parameter int ADDR_W      = DEFAULT_ADDR_W,
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int PRE_SAMPLES = 8,
  parameter int N_SAMPLES   = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              readout_start,
  input  logic [ADDR_W-1:0] address_L0,
  output logic [ADDR_W-1:0] rd_address,
  output logic              rd_en,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_last,
  output logic              busy,
  output logic              readout_end
);

  // Counters need one extra bit so a full-ring window (2^ADDR_W) fits.
  localparam int                CNT_W    = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  N_CNT    = CNT_W'(N_SAMPLES);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(N_SAMPLES - 1);
  localparam logic [ADDR_W-1:0] PRE_OFS  = ADDR_W'(PRE_SAMPLES);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] issued;     // reads issued, modulo the ring depth
  logic [CNT_W-1:0]  remaining;  // reads still to issue
  logic [CNT_W-1:0]  accepted;   // samples accepted by the consumer
  logic              inflight;   // a read issued last cycle returns now

  logic              fifo_valid;
  logic [DATA_W-1:0] fifo_data;
  logic [1:0]        fifo_count;
  logic              pop;
  logic [2:0]        committed;
  logic              slot_free;
  logic              words_done;

  rd_skid_fifo #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (inflight),
    .in_data   (rd_data),
    .out_valid (fifo_valid),
    .out_data  (fifo_data),
    .out_ready (dout_ready),
    .count     (fifo_count)
  );

  assign pop = fifo_valid & dout_ready;

  // Entries already owed to the FIFO after this cycle's pop; a new read may
  // only go out if its word is certain to find a slot two cycles from now.
  assign committed = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign slot_free = (committed < 3'd2);

  assign rd_en       = (state == READ) && (remaining != '0) && slot_free;
  assign rd_address  = start_addr + issued;
  assign busy        = (state != IDLE);
  assign readout_end = (state == END);

`ifdef READ_CHECKSUM_EN
  logic [DATA_W-1:0] sum;
  logic              trailer_valid;

  // Every sample has been accepted, so the FIFO is empty and the trailer
  // owns the output port until it is taken.
  assign trailer_valid = (state == DRAIN) && (accepted == N_CNT);
  assign dout_valid    = fifo_valid | trailer_valid;
  assign dout          = trailer_valid ? sum : fifo_data;
  assign dout_last     = trailer_valid;
  assign words_done    = trailer_valid & dout_ready;
`else
  assign dout_valid    = fifo_valid;
  assign dout          = fifo_data;
  assign dout_last     = fifo_valid && (accepted == LAST_CNT);
  assign words_done    = pop && (accepted == LAST_CNT);
`endif

  always_comb begin
    // NOTE: default first, so no path through the case leaves state_next
    // unassigned and no latch is inferred.
    state_next = state;
    case (state)
      IDLE:    if (readout_start) state_next = READ;
      READ:    if (rd_en && (remaining == CNT_W'(1))) state_next = DRAIN;
      DRAIN:   if (words_done) state_next = END;
      END:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      start_addr <= '0;
      issued     <= '0;
      remaining  <= '0;
      accepted   <= '0;
      inflight   <= 1'b0;
    end else begin
      state    <= state_next;
      inflight <= rd_en;
      if ((state == IDLE) && readout_start) begin
        start_addr <= address_L0 - PRE_OFS;
        issued     <= '0;
        remaining  <= N_CNT;
        accepted   <= '0;
      end
      if (rd_en) begin
        issued    <= issued + ADDR_W'(1);
        remaining <= remaining - CNT_W'(1);
      end
      if (pop) begin
        accepted <= accepted + CNT_W'(1);
      end
    end
  end

`ifdef READ_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum <= '0;
    end else if ((state == IDLE) && readout_start) begin
      sum <= '0;
    end else if (pop) begin
      sum <= sum + fifo_data;
    end
  end
`endif

endmodule : read_control
